control_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU datapath. It is a Moore state machine that steps through fetch (T0–T2) and per-opcode execute states (T3–T7). Each state drives the datapath's bus-out/register-in strobes, ALU opcode, register-select and memory-handshake signals, replacing the hand-sequenced control of the datapath benches. It sits beside the datapath top and samples the IR and the memory ready flag.

---
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping fetch (T0-T2) and per-opcode execute (T3-T7).
// Define MULDIV_EN to decode mul (15) and div (16); without it they trap to FAULT.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        MemReady,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Cout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ALUop,
    output logic        Clear,
    output logic        Run,
    output logic        Fault
);
    localparam logic [4:0] ADD_OP  = 5'b00011;
    localparam logic [4:0] NOP_OP  = 5'b11010;
    localparam logic [4:0] HALT_OP = 5'b11011;

    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT, FAULT} state_t;
    state_t state;

    logic [4:0] op, imm_op;
    logic is_ld, is_ldi, is_st, is_ea, is_alu, is_imm, is_un, is_md, two_op, legal;
    logic t0, t1, t2, t3, t4, t5, t6, t7;
    logic unused_fields;

    // Register-field selection is done in the datapath from Gra/Grb/Grc.
    assign unused_fields = ^IR[26:0];

    assign op     = IR[31:27];
    assign is_ld  = op == 5'd0;
    assign is_ldi = op == 5'd1;
    assign is_st  = op == 5'd2;
    assign is_ea  = is_ld | is_ldi | is_st;
    assign is_alu = op >= 5'd3 && op <= 5'd11;
    assign is_imm = op >= 5'd12 && op <= 5'd14;
    assign is_un  = op == 5'd17 || op == 5'd18;
`ifdef MULDIV_EN
    assign is_md  = op == 5'd15 || op == 5'd16;
`else
    assign is_md  = 1'b0;
`endif
    assign two_op = is_alu | is_imm | is_ea | is_md;
    assign legal  = two_op | is_un;
    assign imm_op = op == 5'd12 ? ADD_OP : op == 5'd13 ? 5'd5 : 5'd6;

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= RST;
        else
            case (state)
                RST:     state <= T0;
                T0:      state <= T1;
                T1:      state <= MemReady ? T2 : T1;
                T2:      state <= op == NOP_OP ? T0 : T3;
                T3:      state <= op == HALT_OP ? HALT : legal ? T4 : FAULT;
                T4:      state <= is_un ? T0 : T5;
                T5:      state <= (is_ld | is_st | is_md) ? T6 : T0;
                T6:      state <= is_md ? T0 : (is_st | MemReady) ? T7 : T6;
                T7:      state <= (is_st & ~MemReady) ? T7 : T0;
                HALT:    state <= HALT;
                FAULT:   state <= FAULT;
                default: state <= RST;
            endcase
    end

    assign t0 = state == T0;
    assign t1 = state == T1;
    assign t2 = state == T2;
    assign t3 = state == T3;
    assign t4 = state == T4;
    assign t5 = state == T5;
    assign t6 = state == T6;
    assign t7 = state == T7;

    assign PCout    = t0;
    assign Zlowout  = t1 | (t4 & is_un) | (t5 & two_op);
    assign ZHighout = t6 & is_md;
    assign MDRout   = t2 | (t7 & is_ld);
    assign BAout    = t3 & is_ea;
    assign Cout     = t4 & (is_imm | is_ea);
    assign Rout     = (t3 & (is_alu | is_imm | is_un | is_md)) | (t4 & (is_alu | is_md)) | (t6 & is_st);
    assign MARin    = t0 | (t5 & (is_ld | is_st));
    assign PCin     = t1;
    assign MDRin    = t1 | (t6 & (is_ld | is_st));
    assign IRin     = t2;
    assign Yin      = t3 & two_op;
    assign ZLowIn   = t0 | (t3 & is_un) | (t4 & two_op);
    assign ZHighIn  = t4 & is_md;
    assign HIin     = t6 & is_md;
    assign LOin     = t5 & is_md;
    assign Rin      = (t4 & is_un) | (t5 & (is_alu | is_imm | is_ldi)) | (t7 & is_ld);
    assign Gra      = (t3 & is_md) | (t4 & is_un) | (t5 & (is_alu | is_imm | is_ldi)) | (t6 & is_st) | (t7 & is_ld);
    assign Grb      = (t3 & (is_alu | is_imm | is_un | is_ea)) | (t4 & is_md);
    assign Grc      = t4 & is_alu;
    assign IncPC    = t0;
    assign Read     = t1 | (t6 & is_ld);
    assign Write    = t7 & is_st;
    assign ALUop    = t0 ? ADD_OP
                    : ((t3 & is_un) | (t4 & (is_alu | is_md))) ? op
                    : (t4 & is_imm) ? imm_op
                    : (t4 & is_ea) ? ADD_OP
                    : 5'd0;
    assign Clear    = state == RST;
    assign Run      = state inside {T0, T1, T2, T3, T4, T5, T6, T7};
    assign Fault    = state == FAULT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: vector table, directed corner sequences and a randomized
// per-opcode micro-step model for control_sequencer.
module tb_control_sequencer;
    logic        Clock = 1'b0, Reset = 1'b1, MemReady = 1'b1;
    logic [31:0] IR = 32'd0;
    logic PCout, Zlowout, ZHighout, MDRout, BAout, Cout, Rout, MARin, PCin, MDRin, IRin, Yin;
    logic ZLowIn, ZHighIn, HIin, LOin, Rin, Gra, Grb, Grc, IncPC, Read, Write, Clear, Run, Fault;
    logic [4:0]  ALUop;
    logic [30:0] outs;
    int n_cmp = 0, n_bad = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .MemReady(MemReady),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout), .BAout(BAout),
        .Cout(Cout), .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .ALUop(ALUop), .Clear(Clear), .Run(Run), .Fault(Fault)
    );

    assign outs = {ALUop, Fault, Run, Clear, Write, Read, IncPC, Grc, Grb, Gra, Rin, LOin, HIin,
                   ZHighIn, ZLowIn, Yin, IRin, MDRin, PCin, MARin, Rout, Cout, BAout, MDRout,
                   ZHighout, Zlowout, PCout};

    localparam logic [30:0] PCO  = 31'd1 << 0,  ZLO  = 31'd1 << 1,  ZHO = 31'd1 << 2;
    localparam logic [30:0] MDRO = 31'd1 << 3,  BAO  = 31'd1 << 4,  CO  = 31'd1 << 5;
    localparam logic [30:0] RO   = 31'd1 << 6,  MARI = 31'd1 << 7,  PCI = 31'd1 << 8;
    localparam logic [30:0] MDRI = 31'd1 << 9,  IRI  = 31'd1 << 10, YI  = 31'd1 << 11;
    localparam logic [30:0] ZLI  = 31'd1 << 12, ZHI  = 31'd1 << 13, HII = 31'd1 << 14;
    localparam logic [30:0] LOI  = 31'd1 << 15, RI   = 31'd1 << 16, GA  = 31'd1 << 17;
    localparam logic [30:0] GB   = 31'd1 << 18, GC   = 31'd1 << 19, INC = 31'd1 << 20;
    localparam logic [30:0] RD   = 31'd1 << 21, WR   = 31'd1 << 22, CLR = 31'd1 << 23;
    localparam logic [30:0] RUN  = 31'd1 << 24, FLT  = 31'd1 << 25;
    localparam logic [30:0] A_ADD = 31'd3 << 26, A_AND = 31'd5 << 26, A_MUL = 31'd15 << 26;
    localparam logic [30:0] W_T0 = RUN | PCO | MARI | INC | ZLI | A_ADD;
    localparam logic [30:0] W_T1 = RUN | ZLO | PCI | RD | MDRI;
    localparam logic [30:0] W_T2 = RUN | MDRO | IRI;
    localparam logic [4:0]  NOP_OP = 5'b11010, HALT_OP = 5'b11011;
    localparam logic [31:0] AND_IR  = 32'h28918000;
    localparam logic [31:0] NOP_IR  = {NOP_OP, 27'd0};
    localparam logic [31:0] HALT_IR = {HALT_OP, 27'd0};
    localparam logic [31:0] BAD_IR  = {5'b11111, 27'd0};
    localparam logic [31:0] LD_IR   = {5'd0, 4'd1, 4'd2, 19'd5};
    localparam logic [31:0] ST_IR   = {5'd2, 4'd0, 4'd1, 19'd9};
    localparam logic [31:0] MUL_IR  = {5'd15, 4'd1, 4'd2, 19'd0};

    typedef struct {
        logic        rst;
        logic [31:0] ir;
        logic        mr;
        logic [30:0] exp;
    } vec_t;
    vec_t tbl[16];

    // Reference model: the expected control word of every micro-step of one instruction.
    logic [30:0] exp_q[$];
    bit          mem_q[$];
    logic [30:0] term;
    bit          sticky;

    function automatic logic [30:0] alu(input logic [4:0] v);
        return {v, 26'd0};
    endfunction

    function automatic void step(input logic [30:0] w, input bit m);
        exp_q.push_back(w | RUN);
        mem_q.push_back(m);
    endfunction

    function automatic void plan(input logic [4:0] op);
        exp_q.delete();
        mem_q.delete();
        sticky = 1'b0;
        term = 31'd0;
        step(W_T0, 1'b0);
        step(W_T1, 1'b1);
        step(W_T2, 1'b0);
        if (op == NOP_OP) return;
        if (op <= 5'd2) begin
            step(GB | BAO | YI, 1'b0);
            step(CO | ZLI | A_ADD, 1'b0);
            if (op == 5'd1) step(ZLO | GA | RI, 1'b0);
            else begin
                step(ZLO | MARI, 1'b0);
                if (op == 5'd0) begin
                    step(RD | MDRI, 1'b1);
                    step(MDRO | GA | RI, 1'b0);
                end else begin
                    step(GA | RO | MDRI, 1'b0);
                    step(WR, 1'b1);
                end
            end
        end else if (op <= 5'd11) begin
            step(GB | RO | YI, 1'b0);
            step(GC | RO | ZLI | alu(op), 1'b0);
            step(ZLO | GA | RI, 1'b0);
        end else if (op <= 5'd14) begin
            step(GB | RO | YI, 1'b0);
            step(CO | ZLI | alu(op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd5 : 5'd6), 1'b0);
            step(ZLO | GA | RI, 1'b0);
        end else if (op == 5'd17 || op == 5'd18) begin
            step(GB | RO | ZLI | alu(op), 1'b0);
            step(ZLO | GA | RI, 1'b0);
`ifdef MULDIV_EN
        end else if (op == 5'd15 || op == 5'd16) begin
            step(GA | RO | YI, 1'b0);
            step(GB | RO | ZLI | ZHI | alu(op), 1'b0);
            step(ZLO | LOI, 1'b0);
            step(ZHO | HII, 1'b0);
`endif
        end else begin
            step(31'd0, 1'b0);
            sticky = 1'b1;
            term = (op == HALT_OP) ? 31'd0 : FLT;
        end
    endfunction

    task automatic check(input string nm, input logic [30:0] got, input logic [30:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: outputs=%h expected=%h", nm, got, want);
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] i, input logic m, input logic [30:0] e, input string nm);
        Reset = r;
        IR = i;
        MemReady = m;
        @(negedge Clock);
        check(nm, outs, e);
        @(posedge Clock);
        #1;
    endtask

    task automatic resync();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        cyc(1'b0, IR, 1'b1, CLR, "rst");
    endtask

    task automatic fetch(input logic [31:0] i, input string nm);
        cyc(1'b0, i, 1'b1, W_T0, {nm, "_t0"});
        cyc(1'b0, i, 1'b1, W_T1, {nm, "_t1"});
        cyc(1'b0, i, 1'b1, W_T2, {nm, "_t2"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] ir;
        logic        m;
        tbl[0]  = '{1'b1, AND_IR, 1'b1, CLR};
        tbl[1]  = '{1'b0, AND_IR, 1'b1, CLR};
        tbl[2]  = '{1'b0, AND_IR, 1'b1, W_T0};
        tbl[3]  = '{1'b0, AND_IR, 1'b1, W_T1};
        tbl[4]  = '{1'b0, AND_IR, 1'b1, W_T2};
        tbl[5]  = '{1'b0, AND_IR, 1'b1, RUN | GB | RO | YI};
        tbl[6]  = '{1'b0, AND_IR, 1'b1, RUN | GC | RO | ZLI | A_AND};
        tbl[7]  = '{1'b0, AND_IR, 1'b1, RUN | ZLO | GA | RI};
        tbl[8]  = '{1'b0, NOP_IR, 1'b1, W_T0};
        tbl[9]  = '{1'b0, NOP_IR, 1'b1, W_T1};
        tbl[10] = '{1'b0, NOP_IR, 1'b1, W_T2};
        tbl[11] = '{1'b0, AND_IR, 1'b1, W_T0};
        tbl[12] = '{1'b0, AND_IR, 1'b0, W_T1};
        tbl[13] = '{1'b0, AND_IR, 1'b0, W_T1};
        tbl[14] = '{1'b0, AND_IR, 1'b1, W_T1};
        tbl[15] = '{1'b0, AND_IR, 1'b1, W_T2};
        @(posedge Clock);
        #1;
        for (int k = 0; k < 16; k++)
            cyc(tbl[k].rst, tbl[k].ir, tbl[k].mr, tbl[k].exp, $sformatf("vec%0d", k));

        // ld with a three-cycle memory stall in T6
        resync();
        fetch(LD_IR, "ld");
        cyc(1'b0, LD_IR, 1'b1, RUN | GB | BAO | YI, "ld_t3");
        cyc(1'b0, LD_IR, 1'b1, RUN | CO | ZLI | A_ADD, "ld_t4");
        cyc(1'b0, LD_IR, 1'b1, RUN | ZLO | MARI, "ld_t5");
        for (int k = 0; k < 3; k++) cyc(1'b0, LD_IR, 1'b0, RUN | RD | MDRI, "ld_t6_wait");
        cyc(1'b0, LD_IR, 1'b1, RUN | RD | MDRI, "ld_t6");
        cyc(1'b0, LD_IR, 1'b1, RUN | MDRO | GA | RI, "ld_t7");
        cyc(1'b0, LD_IR, 1'b1, W_T0, "ld_done");

        // st with the write held until MemReady
        resync();
        fetch(ST_IR, "st");
        cyc(1'b0, ST_IR, 1'b1, RUN | GB | BAO | YI, "st_t3");
        cyc(1'b0, ST_IR, 1'b1, RUN | CO | ZLI | A_ADD, "st_t4");
        cyc(1'b0, ST_IR, 1'b1, RUN | ZLO | MARI, "st_t5");
        cyc(1'b0, ST_IR, 1'b0, RUN | GA | RO | MDRI, "st_t6");
        for (int k = 0; k < 2; k++) cyc(1'b0, ST_IR, 1'b0, RUN | WR, "st_t7_wait");
        cyc(1'b0, ST_IR, 1'b1, RUN | WR, "st_t7");
        cyc(1'b0, ST_IR, 1'b1, W_T0, "st_done");

        // illegal opcode traps, then HALT after reset
        resync();
        fetch(BAD_IR, "bad");
        cyc(1'b0, BAD_IR, 1'b1, RUN, "bad_t3");
        for (int k = 0; k < 20; k++) cyc(1'b0, BAD_IR, 1'($urandom_range(0, 1)), FLT, "fault_stuck");
        cyc(1'b1, BAD_IR, 1'b1, FLT, "fault_rst");
        cyc(1'b0, HALT_IR, 1'b1, CLR, "fault_cleared");
        fetch(HALT_IR, "halt");
        cyc(1'b0, HALT_IR, 1'b1, RUN, "halt_t3");
        for (int k = 0; k < 3; k++) cyc(1'b0, HALT_IR, 1'($urandom_range(0, 1)), 31'd0, "halt_stuck");

        // reset in the middle of a T1 memory wait
        resync();
        cyc(1'b0, AND_IR, 1'b1, W_T0, "abort_t0");
        cyc(1'b0, AND_IR, 1'b0, W_T1, "abort_t1_wait");
        cyc(1'b1, AND_IR, 1'b0, W_T1, "abort_t1_rst");
        cyc(1'b0, AND_IR, 1'b0, CLR, "abort_rst");
        cyc(1'b0, AND_IR, 1'b1, W_T0, "abort_refetch");

        // opcode 15
        resync();
        fetch(MUL_IR, "mul");
`ifdef MULDIV_EN
        cyc(1'b0, MUL_IR, 1'b1, RUN | GA | RO | YI, "mul_t3");
        cyc(1'b0, MUL_IR, 1'b1, RUN | GB | RO | ZLI | ZHI | A_MUL, "mul_t4");
        cyc(1'b0, MUL_IR, 1'b1, RUN | ZLO | LOI, "mul_t5");
        cyc(1'b0, MUL_IR, 1'b1, RUN | ZHO | HII, "mul_t6");
        cyc(1'b0, MUL_IR, 1'b1, W_T0, "mul_done");
`else
        cyc(1'b0, MUL_IR, 1'b1, RUN, "mul_t3");
        cyc(1'b0, MUL_IR, 1'b1, FLT, "mul_fault");
        cyc(1'b0, MUL_IR, 1'b1, FLT, "mul_fault_stuck");
`endif

        // randomized instruction stream against the micro-step model
        resync();
        for (int n = 0; n < 300; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op > 5'd18 && op != NOP_OP && $urandom_range(0, 3) != 0) op = 5'($urandom_range(0, 18));
            ir = {op, 27'($urandom)};
            plan(op);
            for (int k = 0; k < exp_q.size(); ) begin
                m = 1'($urandom_range(0, 3) != 0);
                cyc(1'b0, ir, m, exp_q[k], $sformatf("rand_op%0d_step%0d", op, k));
                if (!mem_q[k] || m) k++;
            end
            if (sticky) begin
                for (int k = 0; k < 2; k++) cyc(1'b0, ir, 1'($urandom_range(0, 1)), term, $sformatf("rand_op%0d_stuck", op));
                cyc(1'b1, ir, 1'b1, term, $sformatf("rand_op%0d_rst", op));
                cyc(1'b0, ir, 1'b1, CLR, "rand_rst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
